ucode_sequencer: RTL and testbench

UCODE_SEQUENCER -- requirements
Module: ucode_sequencer

---
 rtl/ucseq_pkg.sv | 51 +++++
 rtl/ucseq_if.sv | 21 ++
 rtl/ucseq_uaddr_gen.sv | 51 +++++
 rtl/ucode_sequencer.sv | 152 +++++++++++++++
 tb/tb_ucode_sequencer.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/ucseq_pkg.sv
// ucseq_pkg -- shared definitions for the microcode sequencer slice.
//   state_t          : FSM state encoding (M states carry even codes)
//   UW_*_BIT         : microword bit positions of strobes, wait bit, skip field
//   SKIP_TO_*        : skip field codes evaluated in DECODEM
//   is_m_state()     : true for the second half (M) of each two-cycle step
//   is_odd_state()   : true for the first half of each step (HALT excluded)
package ucseq_pkg;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_FETCH   = 4'd1,
    ST_FETCHM  = 4'd2,
    ST_DECODE  = 4'd3,
    ST_DECODEM = 4'd4,
    ST_READ    = 4'd5,
    ST_READM   = 4'd6,
    ST_EXEC    = 4'd7,
    ST_EXECM   = 4'd8,
    ST_HALT    = 4'd9
  } state_t;

  // Microword bit positions
  localparam int UW_MAR_BIT  = 39;
  localparam int UW_IR_BIT   = 38;
  localparam int UW_MDR_BIT  = 37;
  localparam int UW_REG_BIT  = 36;
  localparam int UW_RAM_BIT  = 35;
  localparam int UW_PC_BIT   = 34;
  localparam int UW_WAIT_BIT = 33;
  localparam int UW_BE_BIT   = 32;
  localparam int UW_SKIP_HI  = 4;
  localparam int UW_SKIP_LO  = 3;

  // Skip field codes
  localparam logic [1:0] SKIP_TO_READ      = 2'd0;
  localparam logic [1:0] SKIP_TO_EXEC      = 2'd1;
  localparam logic [1:0] SKIP_TO_FETCH     = 2'd2;
  localparam logic [1:0] SKIP_TO_FETCH_ALT = 2'd3;

  function automatic logic is_m_state(input state_t s);
    return (s == ST_FETCHM) || (s == ST_DECODEM) ||
           (s == ST_READM)  || (s == ST_EXECM);
  endfunction

  // HALT has an odd code but never drives first-half strobes.
  function automatic logic is_odd_state(input state_t s);
    return (s == ST_FETCH) || (s == ST_DECODE) ||
           (s == ST_READ)  || (s == ST_EXEC);
  endfunction

endpackage

// File: rtl/ucseq_if.sv
// ucseq_if -- microaddress bus between the sequencer FSM and the
// microaddress generator.
//   instr : instruction register contents
//   state : current FSM state code
//   uaddr : microcode ROM address derived from state and instr
// Modports:
//   master : sequencer side, supplies instr/state, consumes uaddr
//   slave  : address generator side, consumes instr/state, supplies uaddr
interface ucseq_if #(
  parameter int INSTR_W = 16,
  parameter int UADDR_W = 8
) ();

  logic [INSTR_W-1:0] instr;
  logic [3:0]         state;
  logic [UADDR_W-1:0] uaddr;

  modport master (output instr, output state, input  uaddr);
  modport slave  (input  instr, input  state, output uaddr);

endinterface

// File: rtl/ucseq_uaddr_gen.sv
// ucseq_uaddr_gen -- combinational opcode decode and microaddress mapping.
//   bus.instr, bus.state : inputs (slave modport)
//   bus.uaddr            : ROM address
// Mapping:
//   FETCH/FETCHM   -> FETCH_UADDR
//   DECODE/DECODEM -> opcode
//   READ/READM     -> opcode + 2^(UADDR_W-2)
//   EXEC/EXECM     -> opcode + 2^(UADDR_W-1)
//   otherwise      -> 3
// Opcode: short form {0000, instr[MSB-1:MSB-2]} when instr[MSB]=0,
// long form instr[MSB-1:MSB-6] when instr[MSB]=1.
module ucseq_uaddr_gen
  import ucseq_pkg::*;
#(
  parameter int INSTR_W     = 16,
  parameter int UADDR_W     = 8,
  parameter int FETCH_UADDR = 2
) (
  ucseq_if.slave bus
);

  localparam logic [UADDR_W-1:0] READ_BASE = {2'b01, {(UADDR_W-2){1'b0}}};
  localparam logic [UADDR_W-1:0] EXEC_BASE = {1'b1, {(UADDR_W-1){1'b0}}};
  localparam logic [UADDR_W-1:0] FETCH_A   = UADDR_W'(FETCH_UADDR);
  localparam logic [UADDR_W-1:0] OTHER_A   = UADDR_W'(3);

  logic [5:0]         opcode;
  logic [UADDR_W-1:0] opcode_ext;

  always_comb begin
    if (bus.instr[INSTR_W-1]) begin
      opcode = bus.instr[INSTR_W-2:INSTR_W-7];
    end else begin
      opcode = {4'b0000, bus.instr[INSTR_W-2:INSTR_W-3]};
    end
  end

  assign opcode_ext = {{(UADDR_W-6){1'b0}}, opcode};

  always_comb begin
    bus.uaddr = OTHER_A;
    case (state_t'(bus.state))
      ST_FETCH,  ST_FETCHM:  bus.uaddr = FETCH_A;
      ST_DECODE, ST_DECODEM: bus.uaddr = opcode_ext;
      ST_READ,   ST_READM:   bus.uaddr = opcode_ext + READ_BASE;
      ST_EXEC,   ST_EXECM:   bus.uaddr = opcode_ext + EXEC_BASE;
      default:               bus.uaddr = OTHER_A;
    endcase
  end

endmodule

// File: rtl/ucode_sequencer.sv
// ucode_sequencer -- microcode sequencer FSM with strobe qualification.
// Ports:
//   clk, reset            : rising-edge clock, synchronous active-high reset
//   instr                 : instruction register contents
//   irq                   : interrupt request level
//   mem_ack               : memory transfer complete
//   uword                 : microword from external combinational ROM
//   uaddr                 : ROM address (combinational from state and instr)
//   state                 : current FSM state code
//   mar_load, mdr_load    : first-half (odd state) strobes
//   ir_load, reg_load, ram_load, incr_pc, be : M-state strobes
//   skip_ctl, ctrl        : unqualified uword[4:3] / uword[31:0]
//   halt, bank, irq_ack   : halted flag, interrupt bank, interrupt ack
// Configuration macro: UCSEQ_MEM_WAIT_EN -- when defined, an M state whose
// microword wait bit is set holds until mem_ack, and its strobes fire only
// in the acknowledging cycle. When undefined, mem_ack is ignored.
// Handshake: mem_ack acts as the ready for the memory transfer requested by
// the wait bit; the M state completes in the first cycle where wait bit and
// mem_ack are both 1 (or wait bit is 0). All strobes are forced low while
// reset is asserted so an abandoned instruction issues nothing.
module ucode_sequencer
  import ucseq_pkg::*;
#(
  parameter int                 INSTR_W     = 16,
  parameter int                 UWORD_W     = 40,
  parameter int                 UADDR_W     = 8,
  parameter int                 FETCH_UADDR = 2,
  parameter logic [INSTR_W-1:0] HALT_INSTR  = INSTR_W'(16'hfe00)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [INSTR_W-1:0] instr,
  input  logic               irq,
  input  logic               mem_ack,
  input  logic [UWORD_W-1:0] uword,
  output logic [UADDR_W-1:0] uaddr,
  output logic [3:0]         state,
  output logic               mar_load,
  output logic               mdr_load,
  output logic               ir_load,
  output logic               reg_load,
  output logic               ram_load,
  output logic               incr_pc,
  output logic               be,
  output logic [1:0]         skip_ctl,
  output logic [31:0]        ctrl,
  output logic               halt,
  output logic               bank,
  output logic               irq_ack
);

  state_t state_q, state_d;
  logic   bank_q, bank_d;
  logic   m_final;
  logic   odd_st;

  ucseq_if #(.INSTR_W(INSTR_W), .UADDR_W(UADDR_W)) u_bus ();

  assign u_bus.instr = instr;
  assign u_bus.state = state_q;
  assign uaddr       = u_bus.uaddr;

  ucseq_uaddr_gen #(
    .INSTR_W    (INSTR_W),
    .UADDR_W    (UADDR_W),
    .FETCH_UADDR(FETCH_UADDR)
  ) u_uaddr_gen (
    .bus(u_bus)
  );

  assign odd_st = is_odd_state(state_q);

`ifdef UCSEQ_MEM_WAIT_EN
  assign m_final = is_m_state(state_q) && (!uword[UW_WAIT_BIT] || mem_ack);
`else
  logic unused_mem_ack;
  assign unused_mem_ack = mem_ack;
  assign m_final = is_m_state(state_q);
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      bank_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bank_q  <= bank_d;
    end
  end

  // Next-state logic; M states advance only when they are final.
  always_comb begin
    state_d = state_q;
    bank_d  = bank_q;
    if (state_q == ST_FETCH) begin
      bank_d = irq;
    end
    case (state_q)
      ST_IDLE:    state_d = ST_FETCH;
      ST_FETCH:   state_d = ST_FETCHM;
      ST_FETCHM:  if (m_final) state_d = ST_DECODE;
      ST_DECODE:  state_d = (u_bus.instr == HALT_INSTR) ? ST_HALT : ST_DECODEM;
      ST_DECODEM: begin
        if (m_final) begin
          case (uword[UW_SKIP_HI:UW_SKIP_LO])
            SKIP_TO_READ:      state_d = ST_READ;
            SKIP_TO_EXEC:      state_d = ST_EXEC;
            SKIP_TO_FETCH:     state_d = ST_FETCH;
            SKIP_TO_FETCH_ALT: state_d = ST_FETCH;
            default:           state_d = ST_FETCH;
          endcase
        end
      end
      ST_READ:    state_d = ST_READM;
      ST_READM:   if (m_final) state_d = ST_EXEC;
      ST_EXEC:    state_d = ST_EXECM;
      ST_EXECM:   if (m_final) state_d = ST_FETCH;
      ST_HALT:    state_d = ST_HALT;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    mar_load = 1'b0;
    mdr_load = 1'b0;
    ir_load  = 1'b0;
    reg_load = 1'b0;
    ram_load = 1'b0;
    incr_pc  = 1'b0;
    be       = 1'b0;
    irq_ack  = 1'b0;
    if (!reset) begin
      mar_load = odd_st  & uword[UW_MAR_BIT];
      mdr_load = odd_st  & uword[UW_MDR_BIT];
      ir_load  = m_final & uword[UW_IR_BIT];
      reg_load = m_final & uword[UW_REG_BIT];
      ram_load = m_final & uword[UW_RAM_BIT];
      incr_pc  = m_final & uword[UW_PC_BIT];
      be       = m_final & uword[UW_BE_BIT];
      irq_ack  = (state_q == ST_FETCH) & irq;
    end
  end

  assign state    = state_q;
  assign halt     = (state_q == ST_HALT);
  assign bank     = bank_q;
  assign skip_ctl = uword[UW_SKIP_HI:UW_SKIP_LO];
  assign ctrl     = uword[31:0];

endmodule

// File: tb/tb_ucode_sequencer.sv
// tb_ucode_sequencer -- directed-vector bench for ucode_sequencer.
module tb_ucode_sequencer;

  logic        clk;
  logic        reset;
  logic        irq;
  logic        mem_ack;
  logic [39:0] uword;
  logic        mar_load, mdr_load, ir_load, reg_load, ram_load, incr_pc, be;
  logic [1:0]  skip_ctl;
  logic [31:0] ctrl;
  logic        halt, bank, irq_ack;
  logic [6:0]  strb;

  int vec_cnt  = 0;
  int miscmp   = 0;
  int pc_cnt;

  int st_seq [9] = '{1, 2, 3, 4, 5, 6, 7, 8, 1};
  int ua_seq [9] = '{2, 2, 0, 0, 64, 64, 128, 128, 2};

  ucseq_if #(.INSTR_W(16), .UADDR_W(8)) bus ();

  ucode_sequencer dut (
    .clk     (clk),
    .reset   (reset),
    .instr   (bus.instr),
    .irq     (irq),
    .mem_ack (mem_ack),
    .uword   (uword),
    .uaddr   (bus.uaddr),
    .state   (bus.state),
    .mar_load(mar_load),
    .mdr_load(mdr_load),
    .ir_load (ir_load),
    .reg_load(reg_load),
    .ram_load(ram_load),
    .incr_pc (incr_pc),
    .be      (be),
    .skip_ctl(skip_ctl),
    .ctrl    (ctrl),
    .halt    (halt),
    .bank    (bank),
    .irq_ack (irq_ack)
  );

  assign strb = {mar_load, mdr_load, ir_load, reg_load, ram_load, incr_pc, be};

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Checker
  task automatic chk_vec(input string tag, input logic [39:0] got, input logic [39:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miscmp++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    reset     = 1'b1;
    bus.instr = 16'h0000;
    irq       = 1'b0;
    mem_ack   = 1'b0;
    uword     = 40'h0;
    step();
    step();
    chk_vec("rst_state",   40'(bus.state), 40'd0);
    chk_vec("rst_halt",    40'(halt),      40'd0);
    chk_vec("rst_bank",    40'(bank),      40'd0);
    chk_vec("rst_irq_ack", 40'(irq_ack),   40'd0);
    chk_vec("rst_strb",    40'(strb),      40'd0);

    // Plain walk through all states with skip=0
    reset = 1'b0;
    settle();
    chk_vec("idle_uaddr", 40'(bus.uaddr), 40'd3);
    for (int i = 0; i < 9; i++) begin
      step();
      chk_vec("walk_state", 40'(bus.state), 40'(st_seq[i]));
      chk_vec("walk_uaddr", 40'(bus.uaddr), 40'(ua_seq[i]));
    end

    // Long opcode 6, skip to EXEC, full strobe pattern
    bus.instr = 16'h8c00;
    uword     = 40'hff_0000_0008;
    mem_ack   = 1'b1;
    settle();
    chk_vec("fetch_strb", 40'(strb), 40'h60);
    step();
    chk_vec("fetchm_strb", 40'(strb), 40'h1f);
    step();
    chk_vec("dec_uaddr", 40'(bus.uaddr), 40'd6);
    chk_vec("dec_strb",  40'(strb),      40'h60);
    step();
    chk_vec("decm_state", 40'(bus.state), 40'd4);
    chk_vec("decm_skip",  40'(skip_ctl),  40'd1);
    chk_vec("decm_ctrl",  40'(ctrl),      40'h8);
    step();
    chk_vec("skip_state", 40'(bus.state), 40'd7);
    chk_vec("exec_uaddr", 40'(bus.uaddr), 40'd134);
    step();
    chk_vec("execm_state", 40'(bus.state), 40'd8);
    step();
    chk_vec("refetch_state", 40'(bus.state), 40'd1);

    // Interrupt capture into bank
    bus.instr = 16'h0000;
    uword     = 40'h0;
    irq       = 1'b1;
    settle();
    chk_vec("irq_ack_fetch", 40'(irq_ack), 40'd1);
    chk_vec("bank_pre",      40'(bank),    40'd0);
    step();
    chk_vec("irq_fetchm_state", 40'(bus.state), 40'd2);
    chk_vec("irq_ack_fetchm",   40'(irq_ack),   40'd0);
    chk_vec("bank_fetchm",      40'(bank),      40'd1);
    for (int i = 0; i < 6; i++) begin
      step();
      chk_vec("bank_hold",    40'(bank),    40'd1);
      chk_vec("irq_ack_hold", 40'(irq_ack), 40'd0);
    end
    chk_vec("irq_execm_state", 40'(bus.state), 40'd8);
    irq = 1'b0;
    step();
    chk_vec("irq0_fetch_state", 40'(bus.state), 40'd1);
    chk_vec("irq0_ack",         40'(irq_ack),   40'd0);
    chk_vec("irq0_bank_fetch",  40'(bank),      40'd1);
    step();
    chk_vec("irq0_bank_fetchm", 40'(bank), 40'd0);

    // Reset in READM abandons the instruction
    repeat (7) step();
    chk_vec("pre_rst_fetch", 40'(bus.state), 40'd1);
    irq = 1'b1;
    step();
    irq = 1'b0;
    repeat (4) step();
    uword = 40'hff_0000_0000;
    settle();
    chk_vec("readm_state",  40'(bus.state), 40'd6);
    chk_vec("readm_bank",   40'(bank),      40'd1);
    reset = 1'b1;
    settle();
    chk_vec("readm_rst_reg",  40'(reg_load), 40'd0);
    chk_vec("readm_rst_strb", 40'(strb),     40'd0);
    step();
    chk_vec("readm_rst_state", 40'(bus.state), 40'd0);
    chk_vec("readm_rst_bank",  40'(bank),      40'd0);
    chk_vec("readm_rst_idle",  40'(strb),      40'd0);

    // Reset beats a halt decode
    bus.instr = 16'hfe00;
    mem_ack   = 1'b1;
    step();
    reset = 1'b0;
    repeat (3) step();
    chk_vec("halt_dec_state", 40'(bus.state), 40'd3);
    chk_vec("halt_dec_uaddr", 40'(bus.uaddr), 40'd63);
    reset = 1'b1;
    step();
    chk_vec("rst_over_halt", 40'(bus.state), 40'd0);

    // Halt
    reset = 1'b0;
    repeat (4) step();
    chk_vec("halt_state", 40'(bus.state), 40'd9);
    chk_vec("halt_flag",  40'(halt),      40'd1);
    chk_vec("halt_strb",  40'(strb),      40'd0);
    chk_vec("halt_uaddr", 40'(bus.uaddr), 40'd3);
    step();
    chk_vec("halt_stay", 40'(bus.state), 40'd9);
    reset = 1'b1;
    step();
    chk_vec("halt_rst_state", 40'(bus.state), 40'd0);
    chk_vec("halt_rst_flag",  40'(halt),      40'd0);

    // Memory wait bit in FETCHM
    reset     = 1'b0;
    bus.instr = 16'h0000;
    uword     = 40'h06_0000_0000;
    mem_ack   = 1'b0;
    step();
    chk_vec("wait_fetch", 40'(bus.state), 40'd1);
    step();
`ifdef UCSEQ_MEM_WAIT_EN
    pc_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      mem_ack = (i == 3);
      settle();
      chk_vec("wait_hold", 40'(bus.state), 40'd2);
      pc_cnt += int'(incr_pc);
      step();
    end
    chk_vec("wait_done",   40'(bus.state), 40'd3);
    chk_vec("wait_pc_cnt", 40'(pc_cnt),    40'd1);
`else
    settle();
    chk_vec("nowait_pc",    40'(incr_pc),   40'd1);
    step();
    chk_vec("nowait_state", 40'(bus.state), 40'd3);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp);
    $finish;
  end

endmodule
